// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/grant types and access width codes for mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic [1:0] {NONE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} grant_t;
    localparam logic [2:0] W_BYTE  = 3'b000;
    localparam logic [2:0] W_HALF  = 3'b001;
    localparam logic [2:0] W_WORD  = 3'b010;
    localparam logic [2:0] W_BYTEU = 3'b100;
    localparam logic [2:0] W_HALFU = 3'b101;
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational winner select between fetch and data requests.
// ARB_RR_EN gives ties to the side not granted last; otherwise D always wins ties.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   iReqMasked,
    input  logic   dReqMasked,
`ifdef ARB_RR_EN
    input  grant_t lastGrant,
`endif
    output grant_t pick
);
    logic dWinsTie;
`ifdef ARB_RR_EN
    assign dWinsTie = lastGrant != GNT_D;
`else
    assign dWinsTie = 1'b1;
`endif
    always_comb pick = (dReqMasked && (!iReqMasked || dWinsTie)) ? GNT_D : iReqMasked ? GNT_I : NONE;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle backing memory port between fetch and data sides,
// with a watchdog timeout; ARB_RR_EN selects round-robin tie-breaking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_width,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_width,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state;
    grant_t        grant, pick;
    logic [CW-1:0] counter;
    logic          iMasked, dMasked, timeout, pickD;
    // the side being acked still shows its old req during RESP, so it may not win again
    assign iMasked = i_req && (state == IDLE || (state == RESP && grant != GNT_I));
    assign dMasked = d_req && (state == IDLE || (state == RESP && grant != GNT_D));
    assign timeout = counter == CW'(TIMEOUT_CYCLES - 1);
    assign pickD   = pick == GNT_D;
    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;
`ifdef ARB_RR_EN
    grant_t lastGrant;
    always_ff @(posedge clk)
        if (rst) lastGrant <= GNT_I;
        else if (pick != NONE) lastGrant <= pick;
`endif
    arb_pick uPick (
        .iReqMasked(iMasked),
        .dReqMasked(dMasked),
`ifdef ARB_RR_EN
        .lastGrant(lastGrant),
`endif
        .pick(pick)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= NONE;
            counter   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_width <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            if (state == ISSUE) begin
                if (mem_ack || timeout) begin
                    state   <= RESP;
                    mem_req <= 1'b0;
                    counter <= '0;
                    i_ack   <= grant == GNT_I;
                    d_ack   <= grant == GNT_D;
                    err     <= !mem_ack;
                    if (grant == GNT_I) i_rdata <= mem_ack ? mem_rdata : '0;
                    else d_rdata <= mem_ack ? mem_rdata : '0;
                end else counter <= counter + 1'b1;
            end else begin
                state   <= pick == NONE ? IDLE : ISSUE;
                grant   <= pick;
                mem_req <= pick != NONE;
                if (pick != NONE) begin
                    mem_we    <= pickD && d_we;
                    mem_width <= pickD ? d_width : W_WORD;
                    mem_addr  <= pickD ? d_addr : i_addr;
                    mem_wdata <= pickD ? d_wdata : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, a transaction-level model compared every cycle,
// plus literal expectations per scenario; ARB_RR_EN changes the expected tie winner.
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    localparam int TO = 4;
    logic clk = 0, rst = 1;
    logic i_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
    logic [2:0] d_width = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [2:0] mem_width;
    logic i_ack, i_stall, d_ack, d_stall, mem_req, mem_we, err;
    int checks = 0, errors = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: one access owns the port until acked or timed out; a response
    // is shown for one cycle, during which the responding side cannot start a new access.
    bit mStarted = 0, mBusy = 0, mErr = 0, mWe = 0, iw, dw, winD, tieD, nErr;
    int mSide = 0, mAckSide = 0, mLast = 1, mIssued = 0, nAck;
    logic [2:0] mWidth = 0;
    logic [31:0] mAddr = 0, mWdata = 0, mIRd = 0, mDRd = 0, resp;

    always @(posedge clk) begin
        if (rst) begin
            mStarted = 1; mBusy = 0; mErr = 0; mAckSide = 0; mLast = 1; mIssued = 0;
            mWe = 0; mWidth = 0; mAddr = 0; mWdata = 0; mIRd = 0; mDRd = 0;
        end else begin
            nAck = 0;
            nErr = 0;
            if (mBusy) begin
                mIssued++;
                if (mem_ack || mIssued == TO) begin
                    nAck = mSide;
                    nErr = !mem_ack;
                    resp = mem_ack ? mem_rdata : 32'h0;
                    if (mSide == 1) mIRd = resp;
                    else mDRd = resp;
                    mBusy = 0;
                end
            end else begin
                iw = i_req && mAckSide != 1;
                dw = d_req && mAckSide != 2;
`ifdef ARB_RR_EN
                tieD = mLast != 2;
`else
                tieD = 1;
`endif
                if (iw || dw) begin
                    winD = dw && (!iw || tieD);
                    mSide = winD ? 2 : 1;
                    mLast = mSide;
                    mBusy = 1;
                    mIssued = 0;
                    mWe = winD && d_we;
                    mWidth = winD ? d_width : 3'b010;
                    mAddr = winD ? d_addr : i_addr;
                    mWdata = winD ? d_wdata : 32'h0;
                end
            end
            mAckSide = nAck;
            mErr = nErr;
        end
    end

    always @(negedge clk) if (mStarted) begin
        chk1("model mem_req", mem_req, mBusy);
        if (mBusy) begin
            chk1("model mem_we", mem_we, mWe);
            chk("model mem_width", 32'(mem_width), 32'(mWidth));
            chk("model mem_addr", mem_addr, mAddr);
            chk("model mem_wdata", mem_wdata, mWdata);
        end
        chk1("model i_ack", i_ack, mAckSide == 1);
        chk1("model d_ack", d_ack, mAckSide == 2);
        chk1("model err", err, mErr);
        chk("model i_rdata", i_rdata, mIRd);
        chk("model d_rdata", d_rdata, mDRd);
        chk1("model i_stall", i_stall, i_req && mAckSide != 1);
        chk1("model d_stall", d_stall, d_req && mAckSide != 2);
    end

    initial begin
        cyc(); cyc();
        rst = 0;
        @(negedge clk);
        chk1("reset mem_req", mem_req, 0);
        chk1("reset i_ack", i_ack, 0);
        chk1("reset d_ack", d_ack, 0);
        chk1("reset err", err, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset i_rdata", i_rdata, 0);
        // single fetch
        cyc(); i_req = 1; i_addr = 32'h100;
        @(negedge clk); chk1("t1 stall c0", i_stall, 1); chk1("t1 mem_req c0", mem_req, 0);
        cyc(); mem_ack = 1; mem_rdata = 32'h0010_0093;
        @(negedge clk); chk1("t1 mem_req c1", mem_req, 1); chk("t1 mem_addr", mem_addr, 32'h100);
        chk("t1 mem_width", 32'(mem_width), 32'(W_WORD)); chk1("t1 stall c1", i_stall, 1);
        cyc(); mem_ack = 0;
        @(negedge clk); chk1("t1 i_ack", i_ack, 1); chk("t1 i_rdata", i_rdata, 32'h0010_0093);
        chk1("t1 stall c2", i_stall, 0);
        cyc(); i_req = 0;
        @(negedge clk); chk1("t1 i_ack c3", i_ack, 0); chk1("t1 mem_req c3", mem_req, 0);
        // spurious mem_ack while idle
        cyc(); mem_ack = 1; mem_rdata = 32'hdead;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("spur mem_req", mem_req, 0); chk1("spur i_ack", i_ack, 0);
            chk1("spur d_ack", d_ack, 0); chk("spur i_rdata", i_rdata, 32'h0010_0093);
            cyc();
        end
        // simultaneous requests: D first
        i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hAA;
        d_width = W_BYTE; mem_ack = 1; mem_rdata = 32'h11;
        @(negedge clk); chk1("t2 d_stall c0", d_stall, 1);
        cyc();
        @(negedge clk); chk1("t2 mem_we", mem_we, 1); chk("t2 mem_width", 32'(mem_width), 32'(W_BYTE));
        chk("t2 mem_addr D", mem_addr, 32'h40); chk("t2 mem_wdata", mem_wdata, 32'hAA);
        cyc(); mem_rdata = 32'h22;
        @(negedge clk); chk1("t2 d_ack c2", d_ack, 1); chk("t2 d_rdata", d_rdata, 32'h11);
        chk1("t2 i_stall c2", i_stall, 1); chk1("t2 mem_req c2", mem_req, 0);
        cyc(); d_req = 0; d_we = 0;
        @(negedge clk); chk1("t2 mem_req c3", mem_req, 1); chk("t2 mem_addr I", mem_addr, 32'h200);
        chk1("t2 mem_we I", mem_we, 0); chk("t2 mem_wdata I", mem_wdata, 0);
        cyc();
        @(negedge clk); chk1("t2 i_ack c4", i_ack, 1); chk("t2 i_rdata", i_rdata, 32'h22);
        cyc(); i_req = 0; mem_ack = 0;
        @(negedge clk); chk1("t2 mem_req c5", mem_req, 0);
        // watchdog timeout on a load
        cyc(); d_req = 1; d_we = 0; d_addr = 32'h80; d_width = W_HALFU;
        @(negedge clk);
        for (int k = 1; k <= TO; k++) begin
            cyc();
            @(negedge clk); chk1("t3 mem_req held", mem_req, 1);
        end
        chk("t3 mem_width", 32'(mem_width), 32'(W_HALFU));
        cyc();
        @(negedge clk); chk1("t3 mem_req end", mem_req, 0); chk1("t3 d_ack", d_ack, 1);
        chk1("t3 err", err, 1); chk("t3 d_rdata", d_rdata, 0);
        cyc(); d_req = 0;
        @(negedge clk); chk1("t3 err clear", err, 0);
        // reset mid-transaction
        cyc(); i_req = 1; i_addr = 32'h300;
        @(negedge clk);
        cyc(); rst = 1;
        @(negedge clk); chk1("t4 mem_req issue", mem_req, 1);
        cyc(); rst = 0; i_addr = 32'h304;
        @(negedge clk); chk1("t4 mem_req after rst", mem_req, 0); chk1("t4 no ack", i_ack, 0);
        chk1("t4 no err", err, 0);
        cyc(); mem_ack = 1; mem_rdata = 32'h33;
        @(negedge clk); chk1("t4 reissue", mem_req, 1); chk("t4 mem_addr", mem_addr, 32'h304);
        cyc(); mem_ack = 0;
        @(negedge clk); chk1("t4 i_ack", i_ack, 1); chk("t4 i_rdata", i_rdata, 32'h33);
        cyc(); i_req = 0;
        // both held: grants alternate D, I, D, I
        cyc(); i_req = 1; d_req = 1; i_addr = 32'h400; d_addr = 32'h500; d_width = W_WORD;
        mem_ack = 1; mem_rdata = 32'h55;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 1 || c == 5) chk("t5 addr D", mem_addr, 32'h500);
            if (c == 3 || c == 7) chk("t5 addr I", mem_addr, 32'h400);
            if (c == 2 || c == 6) chk1("t5 d_ack", d_ack, 1);
            if (c == 4 || c == 8) chk1("t5 i_ack", i_ack, 1);
            cyc();
            if (c == 7) begin i_req = 0; d_req = 0; mem_ack = 0; end
        end
        @(negedge clk); chk1("t5 idle", mem_req, 0);
        // tie after a D grant: round-robin gives it to I, fixed priority to D
        cyc(); d_req = 1; d_addr = 32'h600; mem_ack = 1; mem_rdata = 32'h66;
        cyc(); cyc();
        @(negedge clk); chk1("t6 d_ack", d_ack, 1);
        cyc(); d_req = 0; mem_ack = 0;
        cyc(); i_req = 1; d_req = 1; i_addr = 32'h700; d_addr = 32'h800; mem_ack = 1; mem_rdata = 32'h77;
        cyc();
`ifdef ARB_RR_EN
        @(negedge clk); chk("t6 tie winner", mem_addr, 32'h700);
        cyc();
        @(negedge clk); chk1("t6 tie ack", i_ack, 1);
`else
        @(negedge clk); chk("t6 tie winner", mem_addr, 32'h800);
        cyc();
        @(negedge clk); chk1("t6 tie ack", d_ack, 1);
`endif
        cyc(); i_req = 0; d_req = 0;
        cyc(); mem_ack = 0;
        cyc(); cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one multi-cycle backing memory port between the fetch stage (I-side, read-only) and the memory stage (D-side, read/write).
- Arbitrates between the two sides, sequences each transaction through a small FSM and applies a watchdog timeout.
- Drives per-side stall outputs to the hazard unit so the pipeline freezes while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, number of ISSUE cycles without mem_ack before the arbiter forces an error response; must be >=1.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_W  fetch address, stable while i_req
i_rdata  out  DATA_W  fetch read data, valid with i_ack
i_ack  out  1  one-cycle completion pulse to fetch
i_stall  out  1  i_req & ~i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=store, 0=load
d_width  in  3  access width code (funct3 encoding)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid with d_ack
d_ack  out  1  one-cycle completion pulse to data side
d_stall  out  1  d_req & ~d_ack
mem_req  out  1  backing memory request
mem_we  out  1  backing write enable
mem_width  out  3  backing access width
mem_addr  out  ADDR_W  backing address
mem_wdata  out  DATA_W  backing write data
mem_rdata  in  DATA_W  backing read data, valid with mem_ack
mem_ack  in  1  backing completion
err  out  1  pulses with i_ack/d_ack when the response is a timeout

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, grant=NONE, counter=0.
  - All outputs 0: mem_*, i_ack, d_ack, err, rdata.
- States:
  - IDLE: no transaction.
  - ISSUE: mem_req=1, waiting for mem_ack.
  - RESP: one-cycle ack to the granted side.
- IDLE:
  - On cycle N, pick a winner among the asserted requests and register its request fields into mem_*.
  - I-side: mem_we=0, mem_width=3'b010, mem_wdata=0.
  - Go to ISSUE at N+1.
- ISSUE:
  - mem_req high, mem_* stable, counter increments each cycle.
  - mem_ack=1: capture mem_rdata, go to RESP.
  - counter==TIMEOUT_CYCLES-1 with no mem_ack: go to RESP with err=1 and rdata=0.
- RESP:
  - Assert ack, rdata and err for the granted side; mem_req=0; counter clears.
  - Next winner is chosen from the other side's request only; the acked side's req is masked this cycle because the requester updates it the following cycle.
  - Other side requesting: register its fields, go to ISSUE.
  - Otherwise: go to IDLE.
- Latency: minimum 2 cycles from req to ack (req at N, ISSUE N+1 with mem_ack, ack at N+2). Back-to-back requests from alternating sides complete one every 2 cycles.
- Default priority: D-side wins simultaneous requests, since it is the older instruction.
- mem_ack outside ISSUE is ignored. mem_rdata is sampled only when mem_ack=1 in ISSUE.
- Stalls are combinational from req and ack, so the requester's stall drops in the ack cycle.
- Request dropped while not granted: allowed, no effect. Request dropped while granted: the transaction still completes; the ack is discarded by the requester.
- Reset mid-transaction: return to IDLE immediately; no ack or err is issued; the backing transaction is abandoned (backing memory shares rst).
- Width codes pass through unmodified; the backing memory performs sub-word extension.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. A last_grant register (reset=I, so D wins the first tie) is updated on every ISSUE entry; on simultaneous requests the side not last granted wins.
- Undefined: fixed D-over-I priority; no last_grant register.
- The RESP masking rule applies in both modes.

Decomposition:
- Package mem_arb_pkg holds:
  - state_t enum {IDLE, ISSUE, RESP}.
  - grant_t enum {NONE, GNT_I, GNT_D}.
  - Width constants W_BYTE=3'b000, W_HALF=3'b001, W_WORD=3'b010, W_BYTEU=3'b100, W_HALFU=3'b101.
- Sub-module arb_pick: combinational winner select from (i_req_masked, d_req_masked, last_grant). Its round-robin logic is gated by ARB_RR_EN.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0000_0100, mem_ack on the first ISSUE cycle with mem_rdata=0x0010_0093 -> mem_addr=0x100, mem_width=010; i_ack plus i_rdata=0x0010_0093 two cycles after req; i_stall high for exactly 2 cycles.
- Simultaneous requests, default build: i_req and d_req both on cycle 0, d_we=1, d_addr=0x40, d_wdata=0xAA, d_width=000 -> D issued first with mem_we=1, mem_width=000; d_ack at cycle 2; I issued at cycle 3; i_ack at cycle 4.
- Timeout: TIMEOUT_CYCLES=4, d_req load, mem_ack never asserted -> mem_req high for exactly 4 cycles; then d_ack=1, err=1, d_rdata=0.
- Reset mid-op: rst asserted during ISSUE -> next cycle mem_req=0, state IDLE, no ack; after rst drops, a new i_req completes normally.
- Round-robin (ARB_RR_EN): both requests held continuously with 1-cycle mem_ack -> grants alternate D, I, D, I; one ack every 2 cycles.
- Spurious mem_ack in IDLE with no requests -> no ack, no state change.
